// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// Two-master arbiter sharing one memory request port between an instruction
// fetch unit (IFU) and a load/store unit (LSU).
//
// Build option:
//   ARB_RR_EN  defined   -> simultaneous requests alternate (round robin); the
//                           requester that was not granted last wins.
//              undefined -> LSU has fixed priority over IFU; no last-grant
//                           register is built.
//
// Ports:
//   clock              in   rising-edge clock
//   reset              in   asynchronous active-low reset
//   ifu_reqValid       in   fetch request, held until ifu_respValid
//   ifu_addr[31:0]     in   fetch address
//   ifu_respValid      out  fetch response strobe (one cycle)
//   ifu_rdata[31:0]    out  fetch data, valid with ifu_respValid
//   lsu_reqValid       in   load/store request, held until lsu_respValid
//   lsu_addr[31:0]     in   load/store address
//   lsu_wen            in   1 = store, 0 = load
//   lsu_wdata[31:0]    in   store data
//   lsu_wstrb[3:0]     in   store byte strobes
//   lsu_respValid      out  load/store response strobe (one cycle)
//   lsu_rdata[31:0]    out  load data, valid with lsu_respValid
//   mem_reqValid       out  shared memory request valid
//   mem_addr[31:0]     out  shared memory address
//   mem_wen            out  shared memory write enable
//   mem_wdata[31:0]    out  shared memory write data
//   mem_wstrb[3:0]     out  shared memory byte strobes
//   mem_respValid      in   memory response strobe
//   mem_rdata[31:0]    in   memory response data
// -----------------------------------------------------------------------------
module mem_arb (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,

    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IFU  = 2'd1,
        ARB_LSU  = 2'd2
    } arb_state_e;

    arb_state_e  state_q, state_d;

    // Request captured at grant; replayed to memory while the transaction
    // is outstanding so live requester inputs cannot disturb it.
    logic [31:0] hold_addr_q,  hold_addr_d;
    logic        hold_wen_q,   hold_wen_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [3:0]  hold_wstrb_q, hold_wstrb_d;

`ifdef ARB_RR_EN
    // 1 = LSU was granted most recently, 0 = IFU.
    logic        last_lsu_q, last_lsu_d;
`endif

    logic        grant_ifu;
    logic        grant_lsu;

    // Ungated request/response values; gated by reset before leaving the block.
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        ifu_resp;
    logic        lsu_resp;

    // -------------------------------------------------------------------------
    // Arbitration: only meaningful in ARB_IDLE, decided combinationally so the
    // winner reaches the memory port in the cycle it asks.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == ARB_IDLE) begin
`ifdef ARB_RR_EN
            if (ifu_reqValid && lsu_reqValid) begin
                grant_lsu = ~last_lsu_q;
                grant_ifu =  last_lsu_q;
            end else begin
                grant_lsu = lsu_reqValid;
                grant_ifu = ifu_reqValid;
            end
`else
            grant_lsu = lsu_reqValid;
            grant_ifu = ifu_reqValid & ~lsu_reqValid;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next state, hold-register load and memory-port drive
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_wen_d   = hold_wen_q;
        hold_wdata_d = hold_wdata_q;
        hold_wstrb_d = hold_wstrb_q;
`ifdef ARB_RR_EN
        last_lsu_d   = last_lsu_q;
`endif
        req_valid    = 1'b0;
        req_addr     = 32'd0;
        req_wen      = 1'b0;
        req_wdata    = 32'd0;
        req_wstrb    = 4'd0;
        ifu_resp     = 1'b0;
        lsu_resp     = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_lsu) begin
                    req_valid    = 1'b1;
                    req_addr     = lsu_addr;
                    req_wen      = lsu_wen;
                    req_wdata    = lsu_wdata;
                    req_wstrb    = lsu_wstrb;
                    hold_addr_d  = lsu_addr;
                    hold_wen_d   = lsu_wen;
                    hold_wdata_d = lsu_wdata;
                    hold_wstrb_d = lsu_wstrb;
`ifdef ARB_RR_EN
                    last_lsu_d   = 1'b1;
`endif
                    // A same-cycle response finishes the transaction here.
                    if (mem_respValid) begin
                        lsu_resp = 1'b1;
                    end else begin
                        state_d  = ARB_LSU;
                    end
                end else if (grant_ifu) begin
                    // Fetches are always reads: write controls forced low.
                    req_valid    = 1'b1;
                    req_addr     = ifu_addr;
                    hold_addr_d  = ifu_addr;
                    hold_wen_d   = 1'b0;
                    hold_wdata_d = 32'd0;
                    hold_wstrb_d = 4'd0;
`ifdef ARB_RR_EN
                    last_lsu_d   = 1'b0;
`endif
                    if (mem_respValid) begin
                        ifu_resp = 1'b1;
                    end else begin
                        state_d  = ARB_IFU;
                    end
                end
                // No request: a stray mem_respValid is ignored.
            end

            ARB_IFU: begin
                req_valid = 1'b1;
                req_addr  = hold_addr_q;
                req_wen   = 1'b0;
                req_wdata = hold_wdata_q;
                req_wstrb = 4'd0;
                if (mem_respValid) begin
                    ifu_resp = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end

            ARB_LSU: begin
                req_valid = 1'b1;
                req_addr  = hold_addr_q;
                req_wen   = hold_wen_q;
                req_wdata = hold_wdata_q;
                req_wstrb = hold_wstrb_q;
                if (mem_respValid) begin
                    lsu_resp = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and hold registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            hold_addr_q  <= 32'd0;
            hold_wen_q   <= 1'b0;
            hold_wdata_q <= 32'd0;
            hold_wstrb_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_wen_q   <= hold_wen_d;
            hold_wdata_q <= hold_wdata_d;
            hold_wstrb_q <= hold_wstrb_d;
        end
    end

`ifdef ARB_RR_EN
    // After reset the LSU counts as last granted, so IFU wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs: forced to zero while reset is held so that live requests
    // cannot leak through the combinational grant path, and an aborted
    // transaction's response is never reported.
    // -------------------------------------------------------------------------
    assign mem_reqValid  = reset & req_valid;
    assign mem_addr      = reset ? req_addr  : 32'd0;
    assign mem_wen       = reset & req_wen;
    assign mem_wdata     = reset ? req_wdata : 32'd0;
    assign mem_wstrb     = reset ? req_wstrb : 4'd0;

    assign ifu_respValid = reset & ifu_resp;
    assign lsu_respValid = reset & lsu_resp;

    // Read data is shared; each side qualifies it with its own strobe.
    assign ifu_rdata     = reset ? mem_rdata : 32'd0;
    assign lsu_rdata     = reset ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
// Self-checking bench for mem_arb: directed scenarios with literal
// expectations, then randomized requester/memory traffic compared every cycle
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arb;

    logic        clock;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_respValid;
    logic [31:0] mem_rdata;

    mem_arb dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wstrb     (lsu_wstrb),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: who owns the memory port (0 none, 1 IFU, 2 LSU),
    // the request it is replaying, and who was granted last.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    int   m_owner    = 0;
    bit   m_last_lsu = 1'b1;
    txn_t m_txn;
    bit   m_ifu_done = 1'b0;
    bit   m_lsu_done = 1'b0;

    always @(negedge clock) begin
        int   win;
        int   who;
        int   done;
        txn_t cur;
        bit   e_req;
        done = 0;
        who  = 0;
        e_req = 1'b0;
        cur  = '{addr: 32'd0, wen: 1'b0, wdata: 32'd0, wstrb: 4'd0};
        if (!reset) begin
            chk("rst_mem_reqValid", mem_reqValid, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wen", mem_wen, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", mem_wstrb, 0);
            chk("rst_ifu_respValid", ifu_respValid, 0);
            chk("rst_lsu_respValid", lsu_respValid, 0);
            chk("rst_ifu_rdata", ifu_rdata, 0);
            chk("rst_lsu_rdata", lsu_rdata, 0);
            m_owner    = 0;
            m_last_lsu = 1'b1;
        end else begin
            if (m_owner == 0) begin
                win = 0;
                if (ifu_reqValid && lsu_reqValid) begin
`ifdef ARB_RR_EN
                    win = m_last_lsu ? 1 : 2;
`else
                    win = 2;
`endif
                end else if (lsu_reqValid) begin
                    win = 2;
                end else if (ifu_reqValid) begin
                    win = 1;
                end
                if (win == 2) cur = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wstrb: lsu_wstrb};
                if (win == 1) cur = '{addr: ifu_addr, wen: 1'b0, wdata: 32'd0, wstrb: 4'd0};
                if (win != 0) begin
                    e_req      = 1'b1;
                    who        = win;
                    m_last_lsu = (win == 2);
                    if (mem_respValid) begin
                        done = win;
                    end else begin
                        m_owner = win;
                        m_txn   = cur;
                    end
                end
            end else begin
                e_req = 1'b1;
                who   = m_owner;
                cur   = m_txn;
                if (mem_respValid) begin
                    done    = m_owner;
                    m_owner = 0;
                end
            end
            chk("mem_reqValid", mem_reqValid, e_req);
            chk("mem_wen", mem_wen, cur.wen);
            chk("mem_wstrb", mem_wstrb, cur.wstrb);
            if (e_req) chk("mem_addr", mem_addr, cur.addr);
            if (who == 2) chk("mem_wdata", mem_wdata, cur.wdata);
            chk("ifu_respValid", ifu_respValid, done == 1);
            chk("lsu_respValid", lsu_respValid, done == 2);
            chk("ifu_rdata", ifu_rdata, mem_rdata);
            chk("lsu_rdata", lsu_rdata, mem_rdata);
        end
        m_ifu_done = (done == 1);
        m_lsu_done = (done == 2);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b0;
        lsu_wen       = 1'b0;
        lsu_wstrb     = 4'd0;
        mem_respValid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus and literal checks
    // ---------------------------------------------------------------------
    initial begin
        int nreq;
        int nifu;
        int nlsu;
        int got[$];
        int exp_ord[4];
        bit ifu_act;
        bit lsu_act;

        // Reset with every input active: all outputs must read zero.
        reset         = 1'b0;
        ifu_reqValid  = 1'b1;
        ifu_addr      = 32'h0000_0400;
        lsu_reqValid  = 1'b1;
        lsu_addr      = 32'h0000_0800;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h1234_5678;
        lsu_wstrb     = 4'hF;
        mem_respValid = 1'b1;
        mem_rdata     = 32'hABCD_0123;
        #3;
        chk("lit_reset_reqValid", mem_reqValid, 0);
        chk("lit_reset_ifu_rdata", ifu_rdata, 0);
        chk("lit_reset_lsu_resp", lsu_respValid, 0);
        step();
        idle_inputs();
        step();
        reset = 1'b1;

        // IFU fetch, memory answers on the fourth cycle.
        nreq = 0; nifu = 0; nlsu = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            ifu_reqValid  = (k <= 3);
            ifu_addr      = 32'h8000_0000;
            mem_respValid = (k == 3);
            mem_rdata     = (k == 3) ? 32'h0000_0013 : 32'hFFFF_0000 + k;
            #1;
            if (k == 0) chk("lit_fetch_addr", mem_addr, 32'h8000_0000);
            if (mem_reqValid) nreq++;
            if (ifu_respValid) begin
                nifu++;
                chk("lit_fetch_rdata", ifu_rdata, 32'h0000_0013);
            end
            if (lsu_respValid) nlsu++;
        end
        chk("lit_fetch_req_cycles", nreq, 4);
        chk("lit_fetch_resp_count", nifu, 1);
        chk("lit_fetch_lsu_resp", nlsu, 0);

        // LSU store completed in its request cycle.
        step();
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b1;
        lsu_addr      = 32'h0000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wstrb     = 4'hF;
        mem_respValid = 1'b1;
        #1;
        chk("lit_store_resp", lsu_respValid, 1);
        chk("lit_store_addr", mem_addr, 32'h0000_1000);
        chk("lit_store_wen", mem_wen, 1);
        chk("lit_store_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("lit_store_wstrb", mem_wstrb, 4'hF);
        step();
        idle_inputs();
        #1;
        chk("lit_store_back_idle", mem_reqValid, 0);
        // Stray response with no request is ignored.
        step();
        mem_respValid = 1'b1;
        #1;
        chk("lit_stray_ifu_resp", ifu_respValid, 0);
        chk("lit_stray_lsu_resp", lsu_respValid, 0);

        // Tie-breaking over four back-to-back transactions after reset.
        step();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            step();
            ifu_reqValid  = 1'b1;
            ifu_addr      = 32'h0000_0100 + k;
            lsu_reqValid  = 1'b1;
            lsu_addr      = 32'h0000_0200 + k;
            lsu_wen       = 1'b0;
            mem_respValid = k[0];
            #1;
            if (ifu_respValid) got.push_back(1);
            if (lsu_respValid) got.push_back(2);
        end
`ifdef ARB_RR_EN
        exp_ord = '{1, 2, 1, 2};
`else
        exp_ord = '{2, 2, 2, 2};
`endif
        chk("lit_order_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("lit_order", (i < got.size()) ? got[i] : 255, exp_ord[i]);
        end
        step();
        idle_inputs();

        // Address change while LSU transaction is outstanding.
        step();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0000_2000;
        lsu_wen      = 1'b0;
        #1;
        chk("lit_hold_grant_addr", mem_addr, 32'h0000_2000);
        for (int k = 0; k < 3; k++) begin
            step();
            lsu_addr = 32'h0000_3000;
            #1;
            chk("lit_hold_addr", mem_addr, 32'h0000_2000);
        end
        step();
        mem_respValid = 1'b1;
        #1;
        chk("lit_hold_resp_addr", mem_addr, 32'h0000_2000);
        chk("lit_hold_resp", lsu_respValid, 1);
        step();
        idle_inputs();

        // Reset during an IFU transaction aborts it silently.
        step();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h0000_0044;
        step();
        #1;
        chk("lit_abort_busy", mem_reqValid, 1);
        reset = 1'b0;
        #1;
        chk("lit_abort_req_drop", mem_reqValid, 0);
        mem_respValid = 1'b1;
        #1;
        chk("lit_abort_no_resp", ifu_respValid, 0);
        step();
        idle_inputs();
        step();
        reset = 1'b1;
        #1;
        chk("lit_abort_idle", mem_reqValid, 0);
        step();
        mem_respValid = 1'b1;
        #1;
        chk("lit_abort_idle_resp", ifu_respValid, 0);
        step();
        idle_inputs();

        // Requester withdraws mid-transaction; response still delivered.
        step();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h0000_0100;
        step();
        ifu_reqValid = 1'b0;
        #1;
        chk("lit_drop_busy", mem_reqValid, 1);
        chk("lit_drop_addr", mem_addr, 32'h0000_0100);
        step();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0055;
        #1;
        chk("lit_drop_resp", ifu_respValid, 1);
        chk("lit_drop_rdata", ifu_rdata, 32'h0000_0055);
        step();
        idle_inputs();

        // Randomized traffic against the reference model.
        ifu_act = 1'b0;
        lsu_act = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                reset   = 1'b0;
                ifu_act = 1'b0;
                lsu_act = 1'b0;
            end
            if (ifu_act) begin
                if (m_ifu_done) ifu_act = 1'b0;
                else if ($urandom_range(0, 15) == 0) ifu_act = 1'b0;
                else if (m_owner == 1 && $urandom_range(0, 3) == 0) ifu_addr = $urandom;
            end
            if (!ifu_act && reset && m_owner != 1 && $urandom_range(0, 2) == 0) begin
                ifu_act  = 1'b1;
                ifu_addr = $urandom;
            end
            if (lsu_act) begin
                if (m_lsu_done) lsu_act = 1'b0;
                else if ($urandom_range(0, 15) == 0) lsu_act = 1'b0;
                else if (m_owner == 2 && $urandom_range(0, 3) == 0) begin
                    lsu_addr  = $urandom;
                    lsu_wdata = $urandom;
                    lsu_wstrb = 4'($urandom_range(0, 15));
                    lsu_wen   = 1'($urandom_range(0, 1));
                end
            end
            if (!lsu_act && reset && m_owner != 2 && $urandom_range(0, 2) == 0) begin
                lsu_act   = 1'b1;
                lsu_addr  = $urandom;
                lsu_wdata = $urandom;
                lsu_wstrb = 4'($urandom_range(0, 15));
                lsu_wen   = 1'($urandom_range(0, 1));
            end
            ifu_reqValid  = ifu_act;
            lsu_reqValid  = lsu_act;
            mem_respValid = ($urandom_range(0, 2) == 0);
            mem_rdata     = $urandom;
        end
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
